// File: rtl/cache_snoop_responder_if.sv
// Snoop bus seen by the responder: the op request channel from the bus and
// the 2-bit snoop result returned to it.
//
// Handshake: an op transfers on a rising clk edge where snp_valid && snp_ready.
// The bus holds snp_valid/snp_op/snp_addr stable until that edge. The
// responder raises snp_ready only while idle and never stores a second op.
// c_valid is a single-cycle strobe qualifying C_out and has no back-pressure.
interface cache_snoop_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              snp_valid;
    logic [2:0]        snp_op;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_ready;
    logic [1:0]        C_out;
    logic              c_valid;

    // Bus side: other agents issuing ops and observing the snoop result.
    modport master (
        output snp_valid, snp_op, snp_addr,
        input  snp_ready, C_out, c_valid
    );

    // Responder side.
    modport slave (
        input  snp_valid, snp_op, snp_addr,
        output snp_ready, C_out, c_valid
    );
endinterface

// File: rtl/cache_snoop_responder.sv
// Snoop agent for the L2: accepts a bus op, looks up the local line,
// returns HIT/HITM/NOHIT, writes back a modified line when another agent
// reads it, then tells the MESI FSM which snoop event occurred.
module cache_snoop_responder #(
    parameter int ADDR_W = 32,
    parameter int TO_W   = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    cache_snoop_responder_if.slave bus,
    output logic                   lookup_req,
    output logic [ADDR_W-1:0]      lookup_addr,
    input  logic                   lookup_hit,
    input  logic [1:0]             lookup_state,
    output logic                   flush_req,
    output logic [ADDR_W-1:0]      flush_addr,
    input  logic                   flush_ack,
    output logic [2:0]             nmsg_out,
    output logic                   nmsg_valid,
    output logic                   flush_err,
    output logic                   busy,
    output logic [2:0]             dbg_state_o
);
    // Bus op encodings
    localparam logic [2:0] OP_NULL  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;
    // MESI line states
    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;
    // Snoop result encodings
    localparam logic [1:0] C_HIT   = 2'b00;
    localparam logic [1:0] C_HITM  = 2'b01;
    localparam logic [1:0] C_NOHIT = 2'b10;
    // Messages to the MESI FSM (0 = none sent yet)
    localparam logic [2:0] N_NONE      = 3'd0;
    localparam logic [2:0] N_READ_REQ  = 3'd1;
    localparam logic [2:0] N_WRITE_REQ = 3'd2;
    localparam logic [2:0] N_READ_W_M  = 3'd3;
    localparam logic [2:0] N_INV_CMD   = 3'd4;
    // Timeout fires in the FLUSH cycle where the counter steps onto all-ones
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RESP   = 3'd2,
        S_FLUSH  = 3'd3,
        S_NOTIFY = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [1:0]        c_out_q, c_out_d;
    logic [2:0]        nmsg_q, nmsg_d;
    logic              err_q, err_d;
    logic              op_ok;
    logic [1:0]        resp_c;
    logic [2:0]        msg_c;

    // Decode the lookup result and the message implied by the captured op
    always_comb begin
        op_ok = (bus.snp_op == OP_READ) || (bus.snp_op == OP_WRITE) ||
                (bus.snp_op == OP_INV)  || (bus.snp_op == OP_RWIM);
        resp_c = C_NOHIT;
        if (lookup_hit) begin
            case (lookup_state)
                MESI_S, MESI_E: resp_c = C_HIT;
                MESI_M:         resp_c = C_HITM;
                default:        resp_c = C_NOHIT;
            endcase
        end
        case (op_q)
            OP_READ:  msg_c = N_READ_REQ;
            OP_RWIM:  msg_c = N_READ_W_M;
            OP_WRITE: msg_c = N_WRITE_REQ;
            OP_INV:   msg_c = N_INV_CMD;
            default:  msg_c = N_NONE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            op_q    <= OP_NULL;
            addr_q  <= '0;
            to_q    <= '0;
            c_out_q <= C_NOHIT;
            nmsg_q  <= N_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            c_out_q <= c_out_d;
            nmsg_q  <= nmsg_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a flush ack beats a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        to_d    = to_q;
        c_out_d = c_out_q;
        nmsg_d  = nmsg_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.snp_valid && op_ok) begin
                    op_d    = bus.snp_op;
                    addr_d  = bus.snp_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_RESP;
            S_RESP: begin
                c_out_d = resp_c;
                if (resp_c == C_HITM && (op_q == OP_READ || op_q == OP_RWIM)) begin
                    to_d    = '0;
                    state_d = S_FLUSH;
                end else if (lookup_hit && lookup_state != MESI_I) begin
                    nmsg_d  = msg_c;
                    state_d = S_NOTIFY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                to_d = to_q + TO_ONE;
                if (flush_ack) begin
                    nmsg_d  = msg_c;
                    state_d = S_NOTIFY;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    nmsg_d  = msg_c;
                    state_d = S_NOTIFY;
                end
            end
            S_NOTIFY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; C_out shows the live result while in RESP
    // so it lines up with c_valid, and the held result otherwise
    always_comb begin
        bus.snp_ready = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        lookup_req    = (state_q == S_LOOKUP);
        bus.c_valid   = (state_q == S_RESP);
        bus.C_out     = (state_q == S_RESP) ? resp_c : c_out_q;
        flush_req     = (state_q == S_FLUSH);
        nmsg_valid    = (state_q == S_NOTIFY);
        lookup_addr   = addr_q;
        flush_addr    = addr_q;
        nmsg_out      = nmsg_q;
        flush_err     = err_q;
        dbg_state_o   = state_q;
    end
endmodule

// File: tb/tb_cache_snoop_responder.sv
// Bench for cache_snoop_responder: fixed-latency checks per scenario plus a
// scoreboard of expected snoop results and MESI messages.
`timescale 1ns/1ps
module tb_cache_snoop_responder;
    localparam int ADDR_W = 32;
    localparam int TO_W   = 4;
    localparam int TO_CYC = 15;

    localparam logic [2:0] OP_NULL  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;
    localparam logic [1:0] M_I = 2'd0;
    localparam logic [1:0] M_S = 2'd1;
    localparam logic [1:0] M_E = 2'd2;
    localparam logic [1:0] M_M = 2'd3;
    localparam logic [1:0] C_HIT   = 2'b00;
    localparam logic [1:0] C_HITM  = 2'b01;
    localparam logic [1:0] C_NOHIT = 2'b10;
    localparam logic [2:0] N_READ_REQ  = 3'd1;
    localparam logic [2:0] N_WRITE_REQ = 3'd2;
    localparam logic [2:0] N_READ_W_M  = 3'd3;
    localparam logic [2:0] N_INV_CMD   = 3'd4;

    // Clock and reset
    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    cache_snoop_responder_if #(.ADDR_W(ADDR_W)) bus ();
    logic              lookup_req;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit = 1'b0;
    logic [1:0]        lookup_state = 2'd0;
    logic              flush_req;
    logic [ADDR_W-1:0] flush_addr;
    logic              flush_ack = 1'b0;
    logic [2:0]        nmsg_out;
    logic              nmsg_valid;
    logic              flush_err;
    logic              busy;
    logic [2:0]        dbg_state;

    cache_snoop_responder #(.ADDR_W(ADDR_W), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .bus          (bus),
        .lookup_req   (lookup_req),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_state (lookup_state),
        .flush_req    (flush_req),
        .flush_addr   (flush_addr),
        .flush_ack    (flush_ack),
        .nmsg_out     (nmsg_out),
        .nmsg_valid   (nmsg_valid),
        .flush_err    (flush_err),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_c_q[$];
    logic [2:0] exp_n_q[$];
    int n_lookup = 0;
    int n_nmsg = 0;
    logic [1:0] e_c;
    logic [2:0] e_n;

    // Reference model of the snoop result and message mapping
    function automatic logic [1:0] model_c(input logic hit, input logic [1:0] st);
        if (!hit || st == M_I) return C_NOHIT;
        if (st == M_M) return C_HITM;
        return C_HIT;
    endfunction

    function automatic logic [2:0] model_n(input logic [2:0] op);
        case (op)
            OP_READ:  return N_READ_REQ;
            OP_RWIM:  return N_READ_W_M;
            OP_WRITE: return N_WRITE_REQ;
            OP_INV:   return N_INV_CMD;
            default:  return 3'd0;
        endcase
    endfunction

    // Scoreboard: pop an expected value for every strobe the DUT produces
    always @(negedge clk) begin
        if (lookup_req === 1'b1) n_lookup++;
        if (bus.c_valid === 1'b1) begin
            checks++;
            if (exp_c_q.size() == 0) begin
                errors++;
                $display("FAIL c_out_unexpected: c_valid with C_out=%0d, required no response", bus.C_out);
            end else begin
                e_c = exp_c_q.pop_front();
                if (bus.C_out !== e_c) begin
                    errors++;
                    $display("FAIL c_out: got %0d, expected %0d", bus.C_out, e_c);
                end
            end
        end
        if (nmsg_valid === 1'b1) begin
            n_nmsg++;
            checks++;
            if (exp_n_q.size() == 0) begin
                errors++;
                $display("FAIL nmsg_unexpected: nmsg_valid with nmsg_out=%0d, required no message", nmsg_out);
            end else begin
                e_n = exp_n_q.pop_front();
                if (nmsg_out !== e_n) begin
                    errors++;
                    $display("FAIL nmsg_out: got %0d, expected %0d", nmsg_out, e_n);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive point is 1ns after the active edge; sample point is the falling edge
    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One op that does not flush; checks the cycle-by-cycle latency
    task automatic run_simple(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                              input logic hit, input logic [1:0] st);
        logic notify;
        int nl;
        int nn;
        notify = hit && (st != M_I);
        nl = n_lookup;
        nn = n_nmsg;
        bus.snp_valid = 1'b1;
        bus.snp_op    = op;
        bus.snp_addr  = addr;
        exp_c_q.push_back(model_c(hit, st));
        if (notify) exp_n_q.push_back(model_n(op));
        smp();
        checks++;
        if (bus.snp_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: snp_ready=%b, expected 1", bus.snp_ready);
        end
        drv();
        bus.snp_valid = 1'b0;
        bus.snp_addr  = $urandom();
        smp();
        checks++;
        if (lookup_req !== 1'b1 || lookup_addr !== addr || bus.snp_ready !== 1'b0) begin
            errors++;
            $display("FAIL lookup_c1: req=%b addr=%h ready=%b, expected req=1 addr=%h ready=0",
                     lookup_req, lookup_addr, bus.snp_ready, addr);
        end
        drv();
        lookup_hit   = hit;
        lookup_state = st;
        smp();
        checks++;
        if (bus.c_valid !== 1'b1 || lookup_req !== 1'b0) begin
            errors++;
            $display("FAIL resp_c2: c_valid=%b lookup_req=%b, expected 1/0", bus.c_valid, lookup_req);
        end
        drv();
        lookup_hit   = 1'($urandom_range(0, 1));
        lookup_state = 2'($urandom_range(0, 3));
        smp();
        checks++;
        if (notify) begin
            if (nmsg_valid !== 1'b1 || busy !== 1'b1 || bus.c_valid !== 1'b0) begin
                errors++;
                $display("FAIL notify_c3: nmsg_valid=%b busy=%b c_valid=%b, expected 1/1/0",
                         nmsg_valid, busy, bus.c_valid);
            end
        end else begin
            if (busy !== 1'b0 || bus.snp_ready !== 1'b1 || nmsg_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_c3: busy=%b ready=%b nmsg_valid=%b, expected 0/1/0",
                         busy, bus.snp_ready, nmsg_valid);
            end
        end
        drv();
        smp();
        checks++;
        if (busy !== 1'b0 || bus.snp_ready !== 1'b1 || nmsg_valid !== 1'b0 ||
            n_lookup != nl + 1 || n_nmsg != nn + (notify ? 1 : 0) ||
            bus.C_out !== model_c(hit, st) || (notify && nmsg_out !== model_n(op))) begin
            errors++;
            $display("FAIL done_c4: busy=%b ready=%b lookups=%0d msgs=%0d C_out=%0d nmsg_out=%0d, expected 0/1/%0d/%0d/%0d/%0d",
                     busy, bus.snp_ready, n_lookup - nl, n_nmsg - nn, bus.C_out, nmsg_out,
                     1, notify ? 1 : 0, model_c(hit, st), model_n(op));
        end
        drv();
    endtask

    // Op hitting M that flushes; ack_cyc is the flush cycle carrying the ack (-1 = none)
    task automatic run_flush(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                             input int ack_cyc, input logic exp_err);
        int n_fl;
        n_fl = (ack_cyc < 0) ? TO_CYC : ack_cyc + 1;
        bus.snp_valid = 1'b1;
        bus.snp_op    = op;
        bus.snp_addr  = addr;
        exp_c_q.push_back(C_HITM);
        exp_n_q.push_back(model_n(op));
        smp();
        drv();
        bus.snp_valid = 1'b0;
        smp();
        checks++;
        if (lookup_req !== 1'b1 || lookup_addr !== addr) begin
            errors++;
            $display("FAIL flush_lookup: req=%b addr=%h, expected 1 %h", lookup_req, lookup_addr, addr);
        end
        drv();
        lookup_hit   = 1'b1;
        lookup_state = M_M;
        smp();
        checks++;
        if (bus.c_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp: c_valid=%b, expected 1", bus.c_valid);
        end
        drv();
        lookup_hit = 1'b0;
        flush_ack  = (ack_cyc == 0);
        for (int i = 0; i < n_fl; i++) begin
            smp();
            checks++;
            if (flush_req !== 1'b1 || flush_addr !== addr || nmsg_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold[%0d]: req=%b addr=%h nmsg_valid=%b, expected 1 %h 0",
                         i, flush_req, flush_addr, nmsg_valid, addr);
            end
            drv();
            flush_ack = (i + 1 == ack_cyc);
        end
        smp();
        checks++;
        if (flush_req !== 1'b0 || nmsg_valid !== 1'b1 || flush_err !== exp_err) begin
            errors++;
            $display("FAIL flush_end: req=%b nmsg_valid=%b err=%b, expected 0 1 %b",
                     flush_req, nmsg_valid, flush_err, exp_err);
        end
        drv();
        smp();
        checks++;
        if (busy !== 1'b0 || bus.snp_ready !== 1'b1 || flush_err !== exp_err || nmsg_out !== model_n(op)) begin
            errors++;
            $display("FAIL flush_idle: busy=%b ready=%b err=%b nmsg_out=%0d, expected 0 1 %b %0d",
                     busy, bus.snp_ready, flush_err, nmsg_out, exp_err, model_n(op));
        end
        drv();
    endtask

    task automatic test_reset();
        bus.snp_valid = 1'b0;
        bus.snp_op    = OP_NULL;
        bus.snp_addr  = '0;
        rstb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            smp();
            checks++;
            if (bus.snp_ready !== 1'b1 || lookup_req !== 1'b0 || bus.c_valid !== 1'b0 ||
                flush_req !== 1'b0 || nmsg_valid !== 1'b0 || busy !== 1'b0 ||
                bus.C_out !== C_NOHIT || flush_err !== 1'b0 || nmsg_out !== 3'd0 ||
                lookup_addr !== '0 || flush_addr !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: ready=%b lreq=%b cv=%b freq=%b nv=%b busy=%b C=%0d err=%b msg=%0d la=%h fa=%h",
                         i, bus.snp_ready, lookup_req, bus.c_valid, flush_req, nmsg_valid, busy,
                         bus.C_out, flush_err, nmsg_out, lookup_addr, flush_addr);
            end
            drv();
            flush_ack     = 1'($urandom_range(0, 1));
            bus.snp_valid = 1'($urandom_range(0, 1));
            bus.snp_op    = 3'($urandom_range(1, 4));
            bus.snp_addr  = $urandom();
        end
        bus.snp_valid = 1'b0;
        flush_ack     = 1'b0;
        drv();
        rstb = 1'b1;
        smp();
        checks++;
        if (busy !== 1'b0 || bus.snp_ready !== 1'b1 || bus.C_out !== C_NOHIT) begin
            errors++;
            $display("FAIL reset_release: busy=%b ready=%b C=%0d, expected 0 1 %0d",
                     busy, bus.snp_ready, bus.C_out, C_NOHIT);
        end
        drv();
    endtask

    task automatic test_read_hit();
        // An ack outside FLUSH must change nothing
        flush_ack = 1'b1;
        run_simple(OP_READ, 32'h0000_1000, 1'b1, M_E);
        flush_ack = 1'b0;
        checks++;
        if (flush_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: flush_err=%b, expected 0", flush_err);
        end
    endtask

    task automatic test_rwim_flush();
        run_flush(OP_RWIM, 32'h0000_2040, 4, 1'b0);
    endtask

    task automatic test_invalidate();
        run_simple(OP_INV, 32'h0000_3000, 1'b0, M_S);
        run_simple(OP_INV, 32'h0000_3040, 1'b1, M_I);
        run_simple(OP_INV, 32'h0000_3080, 1'b1, M_S);
        run_simple(OP_WRITE, 32'h0000_30C0, 1'b1, M_M);
        run_simple(OP_INV, 32'h0000_3100, 1'b1, M_M);
    endtask

    task automatic test_null_op();
        int nl;
        nl = n_lookup;
        bus.snp_valid = 1'b1;
        bus.snp_op    = OP_NULL;
        bus.snp_addr  = 32'h0000_7000;
        for (int i = 0; i < 4; i++) begin
            drv();
        end
        bus.snp_valid = 1'b0;
        smp();
        checks++;
        if (busy !== 1'b0 || n_lookup != nl || lookup_addr === 32'h0000_7000) begin
            errors++;
            $display("FAIL null_op: busy=%b lookups=%0d lookup_addr=%h, expected 0 0 not-captured",
                     busy, n_lookup - nl, lookup_addr);
        end
        drv();
    endtask

    task automatic test_ack_at_timeout();
        run_flush(OP_READ, 32'h0000_5000, TO_CYC - 1, 1'b0);
    endtask

    task automatic test_flush_timeout();
        run_flush(OP_READ, 32'h0000_6000, -1, 1'b1);
        run_simple(OP_WRITE, 32'h0000_6040, 1'b1, M_S);
        checks++;
        if (flush_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: flush_err=%b, expected 1", flush_err);
        end
    endtask

    task automatic test_back_to_back();
        int nl;
        nl = n_lookup;
        exp_c_q.push_back(C_HIT);
        exp_n_q.push_back(N_READ_REQ);
        exp_c_q.push_back(C_NOHIT);
        bus.snp_valid = 1'b1;
        bus.snp_op    = OP_READ;
        bus.snp_addr  = 32'h0000_8000;
        smp();
        drv();
        // Second op presented right away and held until accepted
        bus.snp_op   = OP_INV;
        bus.snp_addr = 32'h0000_8080;
        smp();
        checks++;
        if (lookup_req !== 1'b1 || lookup_addr !== 32'h0000_8000 || bus.snp_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: req=%b addr=%h ready=%b, expected 1 00008000 0",
                     lookup_req, lookup_addr, bus.snp_ready);
        end
        drv();
        lookup_hit   = 1'b1;
        lookup_state = M_S;
        smp();
        drv();
        lookup_hit = 1'b0;
        smp();
        checks++;
        if (nmsg_valid !== 1'b1 || bus.snp_ready !== 1'b0 || lookup_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_notify: nv=%b ready=%b lreq=%b, expected 1 0 0",
                     nmsg_valid, bus.snp_ready, lookup_req);
        end
        drv();
        smp();
        checks++;
        if (bus.snp_ready !== 1'b1 || n_lookup != nl + 1) begin
            errors++;
            $display("FAIL b2b_wait: ready=%b lookups=%0d, expected 1 1", bus.snp_ready, n_lookup - nl);
        end
        drv();
        bus.snp_valid = 1'b0;
        smp();
        checks++;
        if (lookup_req !== 1'b1 || lookup_addr !== 32'h0000_8080) begin
            errors++;
            $display("FAIL b2b_second: req=%b addr=%h, expected 1 00008080", lookup_req, lookup_addr);
        end
        drv();
        lookup_hit = 1'b0;
        smp();
        drv();
        smp();
        checks++;
        if (busy !== 1'b0 || n_lookup != nl + 2) begin
            errors++;
            $display("FAIL b2b_done: busy=%b lookups=%0d, expected 0 2", busy, n_lookup - nl);
        end
        drv();
    endtask

    task automatic test_reset_mid_flush();
        int nn;
        nn = n_nmsg;
        exp_c_q.push_back(C_HITM);
        bus.snp_valid = 1'b1;
        bus.snp_op    = OP_READ;
        bus.snp_addr  = 32'h0000_9000;
        smp();
        drv();
        bus.snp_valid = 1'b0;
        smp();
        drv();
        lookup_hit   = 1'b1;
        lookup_state = M_M;
        smp();
        drv();
        lookup_hit = 1'b0;
        smp();
        drv();
        smp();
        checks++;
        if (flush_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flush: flush_req=%b, expected 1", flush_req);
        end
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (flush_req !== 1'b0 || busy !== 1'b0 || bus.snp_ready !== 1'b1 ||
            flush_err !== 1'b0 || bus.C_out !== C_NOHIT) begin
            errors++;
            $display("FAIL async_reset: freq=%b busy=%b ready=%b err=%b C=%0d, expected 0 0 1 0 %0d",
                     flush_req, busy, bus.snp_ready, flush_err, bus.C_out, C_NOHIT);
        end
        drv();
        flush_ack = 1'b1;
        drv();
        flush_ack = 1'b0;
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            drv();
        end
        smp();
        checks++;
        if (n_nmsg != nn || busy !== 1'b0 || flush_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_notify: msgs=%0d busy=%b freq=%b, expected 0 0 0",
                     n_nmsg - nn, busy, flush_req);
        end
        drv();
        run_simple(OP_RWIM, 32'h0000_9040, 1'b1, M_E);
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic       hit;
        logic [1:0] st;
        for (int i = 0; i < 20; i++) begin
            op  = 3'($urandom_range(1, 4));
            hit = 1'($urandom_range(0, 1));
            st  = 2'($urandom_range(0, 3));
            if (hit && st == M_M && (op == OP_READ || op == OP_RWIM)) st = M_E;
            run_simple(op, $urandom() & 32'hFFFF_FFC0, hit, st);
        end
    endtask

    initial begin
        bus.snp_valid = 1'b0;
        bus.snp_op    = OP_NULL;
        bus.snp_addr  = '0;
        test_reset();
        test_read_hit();
        test_rwim_flush();
        test_invalidate();
        test_null_op();
        test_ack_at_timeout();
        test_flush_timeout();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        repeat (3) drv();
        checks++;
        if (exp_c_q.size() != 0 || exp_n_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results and %0d messages outstanding, expected 0 and 0",
                     exp_c_q.size(), exp_n_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
